// File: rtl/des_feistel_iter.sv
// des_feistel_iter
//   Iterative DES core. A 64-bit block and 16 precomputed round keys are
//   accepted in IDLE. The block runs through the 16 Feistel rounds at RPC
//   rounds per clock. The result is held in DONE until the consumer takes it.
//
// Ports
//   clk, rst_n  rising-edge clock and asynchronous active-low reset
//   in_valid    data_in, decrypt and subkeys are valid this cycle
//   in_ready    high in IDLE, meaning a new block can be accepted
//   data_in     plaintext, or ciphertext when decrypt=1
//   decrypt     0 = encrypt, 1 = decrypt (round keys are applied in reverse)
//   subkeys     K1 in [767:720] down to K16 in [47:0]
//   out_valid   data_out holds a completed result
//   out_ready   consumer takes data_out on a rising edge while out_valid=1
//   data_out    registered result
//   busy        high whenever the core is not IDLE
module des_feistel_iter #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  data_in,
  input  logic         decrypt,
  input  logic [767:0] subkeys,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("des_feistel_iter: RPC must be one of 1, 2, 4, 8, 16");
  end

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed as [box][row*16 + col].
  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

  // Permutation tables number bits 1..N from the MSB, as in the DES text.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
    return y;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  chunk;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TBL[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      chunk = x[47-6*b -: 6];
      // Outer bits pick the row, inner four bits pick the column.
      s[31-4*b -: 4] = 4'(SBOX[b][{chunk[5], chunk[0], chunk[4:1]}]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TBL[i]];
    return p;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_n;
  logic [31:0]    l_p1;
  logic [31:0]    r_p1;
  logic [767:0]   keys_p1;
  logic           dec_p1;
  logic [3:0]     rnd_p1;
  logic [31:0]    l_n;
  logic [31:0]    r_n;
  logic           last;

  // The round that finishes on this edge is the one that takes the counter past 15.
  assign last = (rnd_p1 == 4'(16 - RPC));

  // ---- round datapath: RPC chained Feistel rounds off the L/R registers ----
  always_comb begin
    logic [31:0] tmp;
    logic [3:0]  rnd;
    logic [3:0]  idx;
    tmp = '0;
    rnd = '0;
    idx = '0;
    l_n = l_p1;
    r_n = r_p1;
    for (int j = 0; j < RPC; j++) begin
      rnd = rnd_p1 + 4'(j);
      // Decrypt walks the key list backwards: round r uses K(16-r).
      idx = dec_p1 ? (4'd15 - rnd) : rnd;
      tmp = r_n;
      r_n = l_n ^ f_func(r_n, keys_p1[48*(15-int'(idx)) +: 48]);
      l_n = tmp;
    end
  end

  // ---- control FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p1: block state registers and the output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_p1     <= '0;
      r_p1     <= '0;
      keys_p1  <= '0;
      dec_p1   <= 1'b0;
      rnd_p1   <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            {l_p1, r_p1} <= ip_perm(data_in);
            keys_p1      <= subkeys;
            dec_p1       <= decrypt;
            rnd_p1       <= '0;
          end
        end
        RUN: begin
          l_p1   <= l_n;
          r_p1   <= r_n;
          rnd_p1 <= rnd_p1 + 4'(RPC);
          // Halves are swapped before the inverse IP.
          if (last) data_out <= ip_inv({r_n, l_n});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_feistel_iter.sv
// Bench for des_feistel_iter: three instances (RPC = 1, 4, 16) share data
// inputs, each with its own in_valid. Stimulus pushes expected results into a
// per-instance queue; a monitor pops and checks whenever out_valid rises.
module tb_des_feistel_iter;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;
  localparam int LAT [3] = '{16, 4, 1};

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [63:0]  data_out  [3];
  logic [63:0]  data_in;
  logic         decrypt;
  logic [767:0] subkeys;
  logic         out_ready;
  logic [767:0] kvec;

  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q [3][$];
  logic prev_ov [3];
  logic [63:0] held [3];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  des_feistel_iter #(.RPC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in), .decrypt(decrypt), .subkeys(subkeys), .out_valid(out_valid[0]),
    .out_ready(out_ready), .data_out(data_out[0]), .busy(busy[0]));

  des_feistel_iter #(.RPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in), .decrypt(decrypt), .subkeys(subkeys), .out_valid(out_valid[1]),
    .out_ready(out_ready), .data_out(data_out[1]), .busy(busy[1]));

  des_feistel_iter #(.RPC(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in), .decrypt(decrypt), .subkeys(subkeys), .out_valid(out_valid[2]),
    .out_ready(out_ready), .data_out(data_out[2]), .busy(busy[2]));

  // Standard DES key schedule; K1 lands in [767:720].
  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [47:0]  k;
    logic [767:0] ks;
    ks = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
      ks[48*(15-r) +: 48] = k;
    end
    return ks;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Issue one block on lane l; returns the cycle count at the accepting edge.
  task automatic send(input int l, input logic [63:0] din, input logic dec,
                      input logic [63:0] expd, input bit push, output int acc);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready[l] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      chk($sformatf("in_ready timeout lane%0d", l), 64'd0, 64'd1);
      acc = -1;
      return;
    end
    data_in     = din;
    decrypt     = dec;
    in_valid[l] = 1'b1;
    acc = cycle + 1;
    if (push) sb_q[l].push_back('{data: expd, acc: 32'(acc)});
    @(negedge clk);
    in_valid[l] = 1'b0;
  endtask

  task automatic wait_done(input int l);
    int k;
    k = 0;
    while ((sb_q[l].size() != 0 || !in_ready[l]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk($sformatf("completion timeout lane%0d", l), 64'd0, 64'd1);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    for (int l = 0; l < 3; l++) prev_ov[l] = 1'b0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        if (!rst_n) begin
          prev_ov[l] = 1'b0;
        end else begin
          if (out_valid[l] && !prev_ov[l]) begin
            if (sb_q[l].size() == 0) begin
              chk($sformatf("unexpected out_valid lane%0d", l), 64'd1, 64'd0);
            end else begin
              e = sb_q[l].pop_front();
              chk($sformatf("data lane%0d", l), data_out[l], e.data);
              chk($sformatf("latency lane%0d", l), 64'(cycle - int'(e.acc)), 64'(LAT[l]));
            end
            held[l] = data_out[l];
          end else if (out_valid[l]) begin
            chk($sformatf("hold lane%0d", l), data_out[l], held[l]);
          end
          prev_ov[l] = out_valid[l];
        end
      end
    end
  end

  initial begin
    int a1;
    int a2;
    int g;
    logic seen_ov;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    decrypt   = 1'b0;
    subkeys   = '0;
    for (int l = 0; l < 3; l++) in_valid[l] = 1'b0;
    kvec = key_sched(KEY);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset out_valid", 64'(out_valid[0]), 64'd0);
    chk("reset data_out", data_out[0], 64'd0);
    chk("reset in_ready", 64'(in_ready[0]), 64'd1);
    chk("reset busy", 64'(busy[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 64'(in_ready[0]), 64'd1);

    // Encrypt and decrypt, RPC=1
    subkeys = kvec;
    send(0, PT, 1'b0, CT, 1'b1, a1);
    wait_done(0);
    send(0, CT, 1'b1, PT, 1'b1, a1);
    wait_done(0);

    // RPC=4 and RPC=16 builds
    send(1, PT, 1'b0, CT, 1'b1, a1);
    wait_done(1);
    send(2, PT, 1'b0, CT, 1'b1, a1);
    wait_done(2);
    send(2, CT, 1'b1, PT, 1'b1, a1);
    wait_done(2);

    // Input isolation during RUN, then backpressure in DONE
    out_ready = 1'b0;
    send(0, PT, 1'b0, CT, 1'b1, a1);
    g = 0;
    while (!out_valid[0] && g < 100) begin
      for (int w = 0; w < 24; w++) subkeys[32*w +: 32] = $urandom();
      data_in = {$urandom(), $urandom()};
      decrypt = 1'($urandom_range(0, 1));
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("out_valid timeout isolation", 64'd0, 64'd1);
    subkeys = kvec;
    decrypt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("in_ready in DONE", 64'(in_ready[0]), 64'd0);
      in_valid[0] = (i == 3);
      data_in     = 64'hFFFF0000FFFF0000;
    end
    in_valid[0] = 1'b0;
    out_ready   = 1'b1;
    repeat (4) @(negedge clk);
    chk("ignored in_valid in DONE", 64'(busy[0]), 64'd0);

    // Reset after round 8 discards the block
    data_in = PT;
    send(0, PT, 1'b0, CT, 1'b0, a1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-run reset out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid-run reset data_out", data_out[0], 64'd0);
    chk("mid-run reset in_ready", 64'(in_ready[0]), 64'd1);
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen_ov = 1'b1;
    end
    chk("out_valid after discarded block", 64'(seen_ov), 64'd0);
    chk("in_ready after release", 64'(in_ready[0]), 64'd1);
    send(0, PT, 1'b0, CT, 1'b1, a1);
    wait_done(0);

    // Back-to-back, out_ready high
    send(0, PT, 1'b0, CT, 1'b1, a1);
    send(0, CT, 1'b1, PT, 1'b1, a2);
    chk("accept spacing RPC=1", 64'(a2 - a1), 64'd18);
    wait_done(0);
    send(2, PT, 1'b0, CT, 1'b1, a1);
    send(2, CT, 1'b1, PT, 1'b1, a2);
    chk("accept spacing RPC=16", 64'(a2 - a1), 64'd3);
    wait_done(2);

    repeat (3) @(negedge clk);
    for (int l = 0; l < 3; l++)
      chk($sformatf("scoreboard empty lane%0d", l), 64'(sb_q[l].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_feistel_iter.md
DES_FEISTEL_ITER -- requirements
Module: des_feistel_iter

Interface
REQ-001 Parameter RPC, default 1, number of Feistel rounds evaluated per clock; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  data_in, decrypt and subkeys are valid this cycle.
REQ-005 in_ready  output  1  block can accept a new input; equals (state==IDLE).
REQ-006 data_in  input  64  plaintext, or ciphertext when decrypt=1.
REQ-007 decrypt  input  1  0 = encrypt, 1 = decrypt.
REQ-008 subkeys  input  768  16 round keys; K_i occupies bits [48*(16-i)+47 : 48*(16-i)], so K1 = [767:720] and K16 = [47:0].
REQ-009 out_valid  output  1  data_out holds a completed result.
REQ-010 out_ready  input  1  consumer accepts data_out this cycle.
REQ-011 data_out  output  64  registered result.
REQ-012 busy  output  1  high when state is not IDLE.

Function
REQ-013 States: IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; acceptance occurs on a rising edge with in_valid=1.
REQ-015 On acceptance, the block SHALL: apply the codebase IP permutation to data_in; load L0/R0 registers; capture all 768 subkey bits and the decrypt bit into internal registers; clear the round counter; move to RUN.
REQ-016 Changes to subkeys, decrypt or data_in after the acceptance edge SHALL have no effect on the block in flight.
REQ-017 Each round r (0..15) SHALL compute R' = L XOR f(R, key) and L' = R, using the codebase f_function. The key is K_(r+1) when encrypting and K_(16-r) when decrypting.
REQ-018 RUN: each clock SHALL evaluate RPC consecutive rounds combinationally (RPC f_function instances), register the updated L/R, and advance the round counter by RPC. The counter is 4 bits wide and wraps to 0 after round 15.
REQ-019 RUN lasts exactly N = 16/RPC clocks.
REQ-020 On the final RUN edge, data_out SHALL register inverse-IP({R16, L16}) (swap before the inverse IP), out_valid SHALL be set, and the state SHALL move to DONE.
REQ-021 Latency: if acceptance is at edge t, out_valid is first high after edge t+N (16 cycles for RPC=1, 1 cycle for RPC=16).
REQ-022 DONE: out_valid=1, and data_out SHALL be held bit-stable until a rising edge with out_ready=1. On that edge, out_valid is cleared and the state returns to IDLE.
REQ-023 in_ready=0 in RUN and DONE. in_valid in those states SHALL be ignored, with no queuing. Sustained throughput is one block per N+2 cycles.
REQ-024 out_ready has no effect outside DONE.
REQ-025 An RPC value outside the legal set SHALL cause an elaboration-time error.

Reset
REQ-026 While rst_n=0 and immediately after its release: state=IDLE, out_valid=0, data_out=64'h0, busy=0, internal L/R/key/counter registers are 0, and in_ready=1.
REQ-027 Reset asserted during RUN or DONE SHALL discard the block in flight. out_valid SHALL NOT assert for it after release.

Verification
REQ-028 RPC=1, encrypt: subkeys derived from key 133457799BBCDFF1, data_in 0123456789ABCDEF -> data_out 85E813540F0AB405, with out_valid high exactly 16 cycles after acceptance.
REQ-029 RPC=1, decrypt: same subkeys, data_in 85E813540F0AB405 -> data_out 0123456789ABCDEF.
REQ-030 RPC=4 and RPC=16 builds, vector of REQ-028 -> identical data_out, with out_valid after 4 and 1 cycles respectively.
REQ-031 Backpressure and isolation: out_ready held low for 10 cycles in DONE -> data_out stable, in_ready=0, and a concurrent in_valid pulse is ignored. Subkeys randomised during RUN -> result still 85E813540F0AB405.
REQ-032 Reset mid-RUN after round 8 -> out_valid stays 0, data_out=0, and in_ready=1 after release. The next accepted block (REQ-028 vector) yields the correct result.
REQ-033 Back-to-back operation: two blocks, each accepted on the first IDLE cycle with out_ready tied high -> both results correct, and accepts spaced N+2 cycles apart.
